// File: rtl/cla_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-lookahead adder.
// Holds the generate/propagate pair, the pipeline latency and tree sizing functions.
package cla_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  localparam int CLA_LATENCY = 3;

  function automatic int int_pow(int base, int e);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) begin
      if (i < e) r = r * base;
    end
    return r;
  endfunction

  // Number of GROUP-wide levels needed to cover width bits.
  function automatic int tree_levels(int width, int group);
    int lv;
    int span;
    lv   = 0;
    span = 1;
    for (int i = 0; i < 31; i++) begin
      if (span < width) begin
        span = span * group;
        lv   = lv + 1;
      end
    end
    return lv;
  endfunction

  function automatic bit params_ok(int width, int group);
    return ((group == 2) || (group == 4)) && (width >= 4) && ((width % group) == 0);
  endfunction

endpackage

// File: rtl/cla_group_gp.sv
// GROUP-wide generate/propagate cell: combines GROUP child pairs into one group pair
// and resolves the carry into each child from the group carry-in.
module cla_group_gp
  import cla_pkg::*;
#(
  parameter int GROUP = 4
) (
  input  gp_t [GROUP-1:0]  gp_i,
  input  logic             c_i,
  output gp_t              gp_o,
  output logic [GROUP-1:0] c_o
);

  // Group pair and carries kept in separate blocks so the upward sweep never
  // depends on the downward carry path.
  always_comb begin
    gp_o = gp_i[0];
    for (int k = 1; k < GROUP; k++) begin
      gp_o.g = gp_i[k].g | (gp_i[k].p & gp_o.g);
      gp_o.p = gp_o.p & gp_i[k].p;
    end
  end

  always_comb begin
    c_o    = '0;
    c_o[0] = c_i;
    for (int k = 1; k < GROUP; k++) begin
      c_o[k] = gp_i[k-1].g | (gp_i[k-1].p & c_o[k-1]);
    end
  end

endmodule

// File: rtl/cla_tree.sv
// Recursive lookahead tree over W bit pairs (W a power of GROUP): GROUP subtrees
// feed one cla_group_gp node, which hands carries back down to the subtrees.
module cla_lookahead_tree
  import cla_pkg::*;
#(
  parameter int W     = 16,
  parameter int GROUP = 4
) (
  input  gp_t [W-1:0]  gp_i,
  input  logic         c_i,
  output gp_t          gp_o,
  output logic [W-1:0] c_o
);

  if (W == GROUP) begin : g_leaf
    cla_group_gp #(.GROUP(GROUP)) u_cell (
      .gp_i (gp_i),
      .c_i  (c_i),
      .gp_o (gp_o),
      .c_o  (c_o)
    );
  end else begin : g_node
    localparam int SUB = W / GROUP;
    gp_t [GROUP-1:0]  kid_gp;
    logic [GROUP-1:0] kid_c;

    for (genvar k = 0; k < GROUP; k++) begin : g_sub
      cla_lookahead_tree #(.W(SUB), .GROUP(GROUP)) u_sub (
        .gp_i (gp_i[k*SUB +: SUB]),
        .c_i  (kid_c[k]),
        .gp_o (kid_gp[k]),
        .c_o  (c_o[k*SUB +: SUB])
      );
    end

    cla_group_gp #(.GROUP(GROUP)) u_cell (
      .gp_i (kid_gp),
      .c_i  (c_i),
      .gp_o (gp_o),
      .c_o  (kid_c)
    );
  end

endmodule

// File: rtl/cla_adder_pipe.sv
// 3-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Define CLA_ADDER_OVERFLOW_EN to add the registered signed-overflow output out_ovf.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef CLA_ADDER_OVERFLOW_EN
  output logic             out_ovf,
`endif
  output logic [1:0]       out_gp
);

  localparam int LEVELS = tree_levels(WIDTH, GROUP);
  localparam int N_PAD  = int_pow(GROUP, LEVELS);

  if (!params_ok(WIDTH, GROUP)) begin : g_bad_params
    $error("cla_adder_pipe: WIDTH must be >= 4 and a multiple of GROUP, GROUP must be 2 or 4");
  end

  logic init_q;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic accept, ld2, ld3, emit;

  logic [WIDTH-1:0] b_eff;
  logic             c0;

  logic [WIDTH-1:0] g1_q, p1_q;
  logic             c01_q;

  logic [WIDTH:0]   c2_q;
  logic [WIDTH-1:0] p2_q;
  gp_t              gp2_q;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  gp_t              gp3_q;

  gp_t [N_PAD-1:0]  bit_gp;
  logic [N_PAD-1:0] bit_c;
  gp_t              word_gp;
  logic [WIDTH:0]   carry;

  // in_ready stays low until the first edge after reset release.
  assign emit     = v3_q & out_ready;
  assign ld3      = v2_q & (~v3_q | emit);
  assign ld2      = v1_q & (~v2_q | ld3);
  assign in_ready = init_q & (~v1_q | ld2);
  assign accept   = in_valid & in_ready;

  always_comb begin
    v1_d = accept | (v1_q & ~ld2);
    v2_d = ld2 | (v2_q & ~ld3);
    v3_d = ld3 | (v3_q & ~emit);
  end

  assign b_eff = in_sub ? ~in_b : in_b;
  assign c0    = in_sub | in_cin;

  // Padding bits (g=0, p=1) pass carries through without changing the word pair.
  for (genvar i = 0; i < N_PAD; i++) begin : g_bits
    if (i < WIDTH) begin : g_real
      assign bit_gp[i] = '{g: g1_q[i], p: p1_q[i]};
    end else begin : g_pad
      assign bit_gp[i] = '{g: 1'b0, p: 1'b1};
    end
  end

  cla_lookahead_tree #(.W(N_PAD), .GROUP(GROUP)) u_tree (
    .gp_i (bit_gp),
    .c_i  (c01_q),
    .gp_o (word_gp),
    .c_o  (bit_c)
  );

  assign carry[WIDTH-1:0] = bit_c[WIDTH-1:0];
  assign carry[WIDTH]     = word_gp.g | (word_gp.p & c01_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      g1_q   <= '0;
      p1_q   <= '0;
      c01_q  <= 1'b0;
      c2_q   <= '0;
      p2_q   <= '0;
      gp2_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      gp3_q  <= '0;
    end else begin
      init_q <= 1'b1;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      if (accept) begin
        g1_q  <= in_a & b_eff;
        p1_q  <= in_a ^ b_eff;
        c01_q <= c0;
      end
      if (ld2) begin
        c2_q  <= carry;
        p2_q  <= p1_q;
        gp2_q <= word_gp;
      end
      if (ld3) begin
        sum_q  <= p2_q ^ c2_q[WIDTH-1:0];
        cout_q <= c2_q[WIDTH];
        gp3_q  <= gp2_q;
      end
    end
  end

  assign out_valid = v3_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_gp    = {gp3_q.g, gp3_q.p};

`ifdef CLA_ADDER_OVERFLOW_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (ld3) begin
      ovf_q <= c2_q[WIDTH] ^ c2_q[WIDTH-1];
    end
  end

  assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe: directed vector table, handshake corner
// sequences and random streams on a 16/4 and a 32/2 instance.
module tb_cla_adder_pipe;
  import cla_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        iv16, ir16, cin16, sub16, ov16, or16, cout16;
  logic [15:0] a16, b16, sum16;
  logic [1:0]  gp16;
  logic        iv32, ir32, cin32, sub32, ov32, or32, cout32;
  logic [31:0] a32, b32, sum32;
  logic [1:0]  gp32;
`ifdef CLA_ADDER_OVERFLOW_EN
  logic        ovf16, ovf32;
`endif

  cla_adder_pipe #(.WIDTH(16), .GROUP(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .in_a(a16), .in_b(b16), .in_cin(cin16), .in_sub(sub16),
    .out_valid(ov16), .out_ready(or16), .out_sum(sum16), .out_cout(cout16),
`ifdef CLA_ADDER_OVERFLOW_EN
    .out_ovf(ovf16),
`endif
    .out_gp(gp16)
  );

  cla_adder_pipe #(.WIDTH(32), .GROUP(2)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
    .in_a(a32), .in_b(b32), .in_cin(cin32), .in_sub(sub32),
    .out_valid(ov32), .out_ready(or32), .out_sum(sum32), .out_cout(cout32),
`ifdef CLA_ADDER_OVERFLOW_EN
    .out_ovf(ovf32),
`endif
    .out_gp(gp32)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic [1:0]  gp;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic [1:0]  gp;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer add of a + b_eff + c0 at width w.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    logic [63:0] mask, aa, be, full, half;
    res_t r;
    mask   = (64'd1 << w) - 64'd1;
    aa     = {32'd0, a} & mask;
    be     = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
    full   = aa + be + {63'd0, (sub | cin)};
    half   = aa + be;
    r.sum  = full[31:0] & mask[31:0];
    r.cout = full[w];
    r.gp   = {half[w], ((aa ^ be) == mask)};
    r.ovf  = (aa[w-1] == be[w-1]) && (full[w-1] != aa[w-1]);
    return r;
  endfunction

  task automatic single16(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [15:0] es,
                          input logic ec, input logic [1:0] eg, input logic eo);
    int cyc;
    @(negedge clk);
    or16 = 1'b1; a16 = a; b16 = b; cin16 = cin; sub16 = sub; iv16 = 1'b1;
    #1;
    cyc = 0;
    while (!ir16 && cyc < 10) begin
      @(negedge clk); #1; cyc++;
    end
    check({name, " in_ready"}, 64'(ir16), 64'd1);
    @(negedge clk);
    iv16 = 1'b0;
    cyc  = 1;
    while (!ov16 && cyc < 10) begin
      @(negedge clk); cyc++;
    end
    check({name, " latency"}, 64'(cyc), 64'(CLA_LATENCY));
    check({name, " sum"}, 64'(sum16), 64'(es));
    check({name, " cout"}, 64'(cout16), 64'(ec));
    check({name, " gp"}, 64'(gp16), 64'(eg));
`ifdef CLA_ADDER_OVERFLOW_EN
    check({name, " ovf"}, 64'(ovf16), 64'(eo));
`else
    if (eo === 1'bx) check({name, " ovf ref"}, 64'(eo), 64'd0);
`endif
  endtask

  // Streams beats through the 16-bit DUT; rnd=0 uses out_ready pattern 1,0,0.
  task automatic stream16(input int beats, input bit rnd, input string tag);
    res_t q[$];
    res_t e;
    int sent = 0, got = 0, cyc = 0;
    while (got < beats && cyc < beats * 8 + 100) begin
      @(negedge clk);
      cyc++;
      or16 = rnd ? ($urandom_range(0, 3) != 0) : ((cyc % 3) == 1);
      if (sent < beats && (!rnd || $urandom_range(0, 4) != 0)) begin
        iv16 = 1'b1;
        if (rnd) begin
          a16 = 16'($urandom); b16 = 16'($urandom);
          cin16 = 1'($urandom); sub16 = 1'($urandom);
        end else begin
          a16 = 16'h1111 * 16'(sent + 1); b16 = 16'h0F0F;
          cin16 = 1'b1; sub16 = sent[0];
        end
      end else begin
        iv16 = 1'b0;
      end
      #1;
      if (ov16) begin
        if (q.size() == 0) begin
          check({tag, " spurious out_valid"}, 64'd1, 64'd0);
        end else begin
          e = q[0];
          check({tag, " result"}, {29'd0, sum16, cout16, gp16}, {29'd0, e.sum[15:0], e.cout, e.gp});
`ifdef CLA_ADDER_OVERFLOW_EN
          check({tag, " ovf"}, 64'(ovf16), 64'(e.ovf));
`endif
          if (or16) begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (iv16 && ir16) begin
        q.push_back(model(16, {16'd0, a16}, {16'd0, b16}, cin16, sub16));
        sent++;
      end
    end
    iv16 = 1'b0;
    check({tag, " result count"}, 64'(got), 64'(beats));
  endtask

  task automatic stream32(input int beats, input string tag);
    res_t q[$];
    res_t e;
    int sent = 0, got = 0, cyc = 0;
    while (got < beats && cyc < beats * 8 + 100) begin
      @(negedge clk);
      cyc++;
      or32 = ($urandom_range(0, 3) != 0);
      if (sent < beats && $urandom_range(0, 4) != 0) begin
        iv32 = 1'b1;
        a32 = $urandom; b32 = $urandom;
        cin32 = 1'($urandom); sub32 = 1'($urandom);
      end else begin
        iv32 = 1'b0;
      end
      #1;
      if (ov32) begin
        if (q.size() == 0) begin
          check({tag, " spurious out_valid"}, 64'd1, 64'd0);
        end else begin
          e = q[0];
          check({tag, " result"}, {29'd0, sum32, cout32, gp32}, {29'd0, e.sum, e.cout, e.gp});
`ifdef CLA_ADDER_OVERFLOW_EN
          check({tag, " ovf"}, 64'(ovf32), 64'(e.ovf));
`endif
          if (or32) begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (iv32 && ir32) begin
        q.push_back(model(32, a32, b32, cin32, sub32));
        sent++;
      end
    end
    iv32 = 1'b0;
    check({tag, " result count"}, 64'(got), 64'(beats));
  endtask

  task automatic fill16(output int acc, output res_t exp_q[$]);
    acc = 0;
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      or16 = 1'b0; iv16 = 1'b1;
      a16 = 16'h0100 + 16'(k); b16 = 16'h0010; cin16 = 1'b0; sub16 = 1'b0;
      #1;
      if (ir16) begin
        exp_q.push_back(model(16, {16'd0, a16}, {16'd0, b16}, cin16, sub16));
        acc++;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    res_t exp_q[$];
    int   acc, got, cyc;
    bit   seen;

    tbl[0] = '{a: 16'h1234, b: 16'h4321, cin: 1'b1, sub: 1'b0, sum: 16'h5556, cout: 1'b0, gp: 2'b00, ovf: 1'b0};
    tbl[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sub: 1'b0, sum: 16'h0000, cout: 1'b1, gp: 2'b10, ovf: 1'b0};
    tbl[2] = '{a: 16'h0000, b: 16'h0001, cin: 1'b0, sub: 1'b1, sum: 16'hFFFF, cout: 1'b0, gp: 2'b00, ovf: 1'b0};
    tbl[3] = '{a: 16'h8000, b: 16'h0001, cin: 1'b0, sub: 1'b1, sum: 16'h7FFF, cout: 1'b1, gp: 2'b10, ovf: 1'b1};
    tbl[4] = '{a: 16'h00FF, b: 16'hFF00, cin: 1'b1, sub: 1'b0, sum: 16'h0000, cout: 1'b1, gp: 2'b01, ovf: 1'b0};
    tbl[5] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, sub: 1'b0, sum: 16'h8000, cout: 1'b0, gp: 2'b00, ovf: 1'b1};
    tbl[6] = '{a: 16'h0005, b: 16'h0003, cin: 1'b0, sub: 1'b1, sum: 16'h0002, cout: 1'b1, gp: 2'b10, ovf: 1'b0};
    tbl[7] = '{a: 16'h1234, b: 16'h1234, cin: 1'b0, sub: 1'b1, sum: 16'h0000, cout: 1'b1, gp: 2'b01, ovf: 1'b0};

    rst_n = 1'b0;
    iv16 = 1'b1; a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b1; sub16 = 1'b0; or16 = 1'b1;
    iv32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; or32 = 1'b1;

    // Reset held with in_valid asserted: nothing may come out.
    repeat (4) @(negedge clk);
    check("reset out_valid", 64'(ov16), 64'd0);
    check("reset out_sum", 64'(sum16), 64'd0);
    check("reset cout/gp", {62'd0, cout16, gp16[1] | gp16[0]}, 64'd0);
    iv16  = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after release", 64'(ir16), 64'd1);
    check("out_valid after release", 64'(ov16), 64'd0);

    for (int i = 0; i < 8; i++) begin
      single16($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
               tbl[i].sum, tbl[i].cout, tbl[i].gp, tbl[i].ovf);
    end

    stream16(8, 1'b0, "backpressure");

    // Stalled output: only three beats fit before in_ready drops.
    fill16(acc, exp_q);
    check("stall accept count", 64'(acc), 64'd3);
    check("stall in_ready", 64'(ir16), 64'd0);
    iv16 = 1'b0;
    or16 = 1'b1;
    got  = 0;
    cyc  = 0;
    while (got < 3 && cyc < 10) begin
      if (ov16) begin
        check("drain result", {47'd0, sum16, cout16}, {47'd0, exp_q[0].sum[15:0], exp_q[0].cout});
        void'(exp_q.pop_front());
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    check("drain count", 64'(got), 64'd3);

    // Reset with a full pipe: in-flight beats vanish.
    fill16(acc, exp_q);
    check("prefill count", 64'(acc), 64'd3);
    @(negedge clk);
    iv16  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", 64'(ov16), 64'd0);
    repeat (2) @(negedge clk);
    or16  = 1'b1;
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ov16) seen = 1'b1;
    end
    check("stale out_valid after reset", 64'(seen), 64'd0);
    single16("post-reset 1+1", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 2'b00, 1'b0);

    fork
      stream16(2000, 1'b1, "rand16");
      stream32(2000, "rand32");
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
